// File: rtl/data_unpack_gen_if.sv
// data_unpack_gen_if: packed-word input / framed-value output stream bundle for data_unpack_gen
interface data_unpack_gen_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 7
);
    logic             ready_out;
    logic             valid_in;
    logic [IN_W-1:0]  data_in;
    logic             sop_in;
    logic             eop_in;
    logic             valid_out;
    logic [OUT_W-1:0] data_out;
    logic             sop_out;
    logic             eop_out;
    logic             ready_in;
    logic             err_out;

    modport master (
        input  ready_out, valid_out, data_out, sop_out, eop_out, err_out,
        output valid_in, data_in, sop_in, eop_in, ready_in
    );

    modport slave (
        output ready_out, valid_out, data_out, sop_out, eop_out, err_out,
        input  valid_in, data_in, sop_in, eop_in, ready_in
    );
endinterface

// File: rtl/data_unpack_gen.sv
// data_unpack_gen: splits LSB-first packed IN_W-bit words into framed, back-pressurable OUT_W-bit values
module data_unpack_gen #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 7
) (
    input logic              clk,
    input logic              rst_n,
    data_unpack_gen_if.slave bus
);
    localparam int BUF_W = IN_W + 2*OUT_W - 1;
    localparam int CNT_W = $clog2(IN_W + 2*OUT_W + 1);

    typedef enum logic [1:0] {IDLE, PKT, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, shf, ext;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_s;
    logic             first_q, first_d, err_q, err_d;
    logic             acc, pop;

    // ready_out depends only on registered state; the 2*OUT_W threshold keeps output gap-free
    assign bus.ready_out = rst_n & (state_q == IDLE | (state_q == PKT & cnt_q < CNT_W'(2*OUT_W)));
    assign bus.valid_out = (state_q == PKT & cnt_q >= CNT_W'(OUT_W)) | (state_q == FLUSH & cnt_q != '0);
    assign bus.eop_out   = state_q == FLUSH & cnt_q != '0 & cnt_q <= CNT_W'(OUT_W);
    assign bus.sop_out   = bus.valid_out & first_q;
    assign bus.data_out  = buf_q[OUT_W-1:0] & ~({OUT_W{1'b1}} << cnt_q);
    assign bus.err_out   = err_q;

    assign acc   = bus.valid_in & bus.ready_out;
    assign pop   = bus.valid_out & bus.ready_in;
    assign ext   = BUF_W'(bus.data_in);
    assign shf   = pop ? buf_q >> OUT_W : buf_q;
    assign cnt_s = !pop ? cnt_q : cnt_q > CNT_W'(OUT_W) ? cnt_q - CNT_W'(OUT_W) : '0;

    always_comb begin
        state_d = state_q;
        buf_d   = shf;
        cnt_d   = cnt_s;
        first_d = first_q & !pop;
        err_d   = 1'b0;
        if (acc & bus.sop_in) begin
            buf_d   = ext;
            cnt_d   = CNT_W'(IN_W);
            first_d = 1'b1;
            err_d   = state_q == PKT;
            state_d = bus.eop_in ? FLUSH : PKT;
        end else if (acc & state_q == PKT) begin
            buf_d   = shf | (ext << cnt_s);
            cnt_d   = cnt_s + CNT_W'(IN_W);
            state_d = bus.eop_in ? FLUSH : PKT;
        end else if (pop & bus.eop_out) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_W'(BUF_W));
endmodule

// File: tb/tb_data_unpack_gen.sv
// tb_data_unpack_gen: directed checks of data_unpack_gen at 32->7 and 16->5
module tb_data_unpack_gen;
    typedef struct {logic [31:0] d; logic s; logic e;} win_t;
    typedef struct {logic [15:0] d; logic s; logic e; logic r; int cyc;} vout_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n2 = 1'b0;
    int   errs = 0;
    int   checks = 0;
    int   errp, first_acc;
    win_t  wq[$];
    vout_t oq[$];
    vout_t eq[$];

    data_unpack_gen_if #(.IN_W(32), .OUT_W(7)) a ();
    data_unpack_gen_if #(.IN_W(16), .OUT_W(5)) b ();

    data_unpack_gen #(.IN_W(32), .OUT_W(7)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    data_unpack_gen #(.IN_W(16), .OUT_W(5)) dut_b (.clk(clk), .rst_n(rst_n2), .bus(b.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_w(input logic [31:0] d, input logic s, input logic e);
        wq.push_back('{d, s, e});
    endtask

    task automatic exp_v(input logic [15:0] d, input logic s, input logic e);
        eq.push_back('{d, s, e, 1'b0, 0});
    endtask

    // independent reference: whole packet as a bit list, sliced into ow-bit values
    function automatic void model(input int iw, input int ow);
        bit bq[$];
        bit inp = 0;
        eq.delete();
        foreach (wq[i]) begin
            if (wq[i].s) begin
                bq.delete();
                inp = 1;
            end
            if (!inp) continue;
            for (int j = 0; j < iw; j++) bq.push_back(wq[i].d[j]);
            if (wq[i].e) begin
                for (int k = 0; k < (bq.size() + ow - 1) / ow; k++) begin
                    logic [15:0] d;
                    d = '0;
                    for (int j = 0; j < ow; j++) if (k*ow + j < bq.size()) d[j] = bq[k*ow + j];
                    eq.push_back('{d, k == 0, k == (bq.size() + ow - 1) / ow - 1, 1'b0, 0});
                end
                inp = 0;
            end
        end
    endfunction

    task automatic drive(input bit sel, input bit rnd, input int ncyc);
        int          wi = 0;
        bit          stl = 0;
        logic [17:0] held = '0, cur;
        logic        ov, rdy, r, er, vi;
        win_t        w;
        oq.delete();
        errp = 0;
        first_acc = -1;
        for (int c = 0; c < ncyc; c++) begin
            r  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            vi = wi < wq.size();
            if (vi) w = wq[wi];
            else w = '{32'h0, 1'b0, 1'b0};
            if (sel) begin
                b.valid_in = vi; b.data_in = w.d[15:0]; b.sop_in = w.s; b.eop_in = w.e; b.ready_in = r;
            end else begin
                a.valid_in = vi; a.data_in = w.d; a.sop_in = w.s; a.eop_in = w.e; a.ready_in = r;
            end
            ov  = sel ? b.valid_out : a.valid_out;
            rdy = sel ? b.ready_out : a.ready_out;
            er  = sel ? b.err_out : a.err_out;
            cur = sel ? {b.sop_out, b.eop_out, 16'(b.data_out)} : {a.sop_out, a.eop_out, 16'(a.data_out)};
            if (stl && !er) check("stall_hold", {ov, cur}, {1'b1, held});
            if (ov && r) oq.push_back('{cur[15:0], cur[17], cur[16], rdy, c});
            errp += int'(er);
            stl  = ov && !r;
            held = cur;
            if (vi && rdy) begin
                if (wi == 0) first_acc = c;
                wi++;
            end
            @(posedge clk);
            #1;
        end
        a.valid_in = 0; a.sop_in = 0; a.eop_in = 0; a.ready_in = 0;
        b.valid_in = 0; b.sop_in = 0; b.eop_in = 0; b.ready_in = 0;
        check("words_taken", wi, wq.size());
    endtask

    task automatic cmp(input string tag);
        check({tag, "_count"}, oq.size(), eq.size());
        for (int i = 0; i < oq.size() && i < eq.size(); i++)
            check($sformatf("%s_v%0d", tag, i), {oq[i].s, oq[i].e, oq[i].d}, {eq[i].s, eq[i].e, eq[i].d});
    endtask

    task automatic load_p1;
        push_w(32'hF00CC05A, 1, 0);
        push_w(32'h7D000007, 0, 0);
        push_w(32'h01234567, 0, 0);
        push_w(32'h89ABCDEF, 0, 0);
        push_w(32'hCAFEBABE, 0, 0);
        push_w(32'h0BADF00D, 0, 0);
        push_w(32'h55AA33CC, 0, 1);
    endtask

    initial begin
        a.valid_in = 0; a.data_in = '0; a.sop_in = 0; a.eop_in = 0; a.ready_in = 0;
        b.valid_in = 0; b.data_in = '0; b.sop_in = 0; b.eop_in = 0; b.ready_in = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", a.ready_out, 0);
        check("rst_flags", {a.valid_out, a.sop_out, a.eop_out, a.err_out}, 0);
        rst_n = 1; rst_n2 = 1;
        @(posedge clk);
        #1;
        check("rel_ready", a.ready_out, 1);
        check("rel_valid", a.valid_out, 0);

        // 7-word packet then single sop&eop word, ready_in held high
        wq.delete();
        load_p1();
        push_w(32'hF0000000, 1, 1);
        drive(0, 0, 60);
        model(32, 7);
        cmp("t1");
        check("t1_v0", {oq[0].s, oq[0].d}, {1'b1, 16'h5A});
        check("t1_v1", oq[1].d, 16'h00);
        check("t1_v2", oq[2].d, 16'h33);
        check("t1_v3", oq[3].d, 16'h00);
        check("t1_v4", oq[4].d, 16'h7F);
        check("t1_eop31", oq[31].e, 1);
        check("t1_latency", oq[0].cyc - first_acc, 1);
        for (int i = 1; i < 32; i++) check($sformatf("t1_gap%0d", i), oq[i].cyc - oq[i-1].cyc, 1);
        check("t1_dead", oq[32].cyc - oq[31].cyc, 2);
        for (int i = 32; i < 37; i++) check($sformatf("t2_ready%0d", i), oq[i].r, 0);
        check("t2_first", {oq[32].s, oq[32].e, oq[32].d}, {2'b10, 16'h00});
        check("t2_last", {oq[36].s, oq[36].e, oq[36].d}, {2'b01, 16'h0F});
        check("t1_err", errp, 0);

        // three back-to-back packets with random back-pressure
        wq.delete();
        load_p1();
        push_w(32'hF0000000, 1, 1);
        push_w(32'hDEADBEEF, 1, 0);
        push_w(32'h12345678, 0, 1);
        drive(0, 1, 700);
        model(32, 7);
        cmp("t3");

        // non-sop words in IDLE are discarded
        wq.delete();
        push_w(32'h11111111, 0, 0);
        push_w(32'h22222222, 0, 0);
        push_w(32'h00000003, 1, 1);
        drive(0, 0, 20);
        model(32, 7);
        cmp("t4");
        check("t4_first", {oq[0].s, oq[0].d}, {1'b1, 16'h03});

        // sop mid-packet aborts: four 0x7F values, then the new packet
        wq.delete();
        push_w(32'hFFFFFFFF, 1, 0);
        push_w(32'h00000001, 1, 1);
        drive(0, 0, 30);
        eq.delete();
        exp_v(16'h7F, 1, 0);
        repeat (3) exp_v(16'h7F, 0, 0);
        exp_v(16'h01, 1, 0);
        repeat (3) exp_v(16'h00, 0, 0);
        exp_v(16'h00, 0, 1);
        cmp("t5");
        check("t5_err", errp, 1);

        // 16->5: 48-bit packet gives 10 values, last is bits[47:45] padded
        wq.delete();
        push_w(32'h1234, 1, 0);
        push_w(32'h5678, 0, 0);
        push_w(32'h9ABC, 0, 1);
        drive(1, 0, 40);
        model(16, 5);
        cmp("t6");
        check("t6_v0", {oq[0].s, oq[0].e, oq[0].d}, {2'b10, 16'h14});
        check("t6_v9", {oq[9].s, oq[9].e, oq[9].d}, {2'b01, 16'h04});

        // reset mid-packet, then a clean restart
        wq.delete();
        push_w(32'h1234, 1, 0);
        push_w(32'h5678, 0, 0);
        drive(1, 0, 4);
        rst_n2 = 0;
        #1;
        check("t6_rst_out", {b.ready_out, b.valid_out, b.sop_out, b.eop_out, b.err_out}, 0);
        @(posedge clk);
        #1;
        rst_n2 = 1;
        @(posedge clk);
        #1;
        check("t6_rel_ready", b.ready_out, 1);
        check("t6_rel_valid", b.valid_out, 0);
        wq.delete();
        push_w(32'hABCD, 1, 1);
        drive(1, 0, 20);
        eq.delete();
        exp_v(16'h0D, 1, 0);
        exp_v(16'h1E, 0, 0);
        exp_v(16'h0A, 0, 0);
        exp_v(16'h01, 0, 1);
        cmp("t6r");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
